// File: rtl/axi3_pkg.sv
// Shared definitions for the AXI3 burst memory slave.
//   - AXI3 burst and response encodings
//   - slave FSM state enum
//   - helper that flags size/burst combinations the slave does not serve
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA
    } state_e;

    // Only full-width beats with FIXED or INCR bursts are served; anything
    // else completes normally but answers SLVERR.
    function automatic logic burst_cfg_err(input logic [2:0] size,
                                           input logic [2:0] size_ok,
                                           input logic [1:0] burst);
        return (size != size_ok) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables.
//   i_clk   : clock
//   i_v     : access enable (read or write)
//   i_w     : 1 = write, 0 = read
//   i_addr  : word address
//   i_data  : write data
//   i_wmask : byte write enables, one per byte lane
//   o_data  : registered read data; holds its value when no read is issued
// Contents are not reset.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p        = 8192,
    parameter int data_width_p = 64,
    parameter int addr_width_p = $clog2(els_p)
) (
    input  logic                      i_clk,
    input  logic                      i_v,
    input  logic                      i_w,
    input  logic [addr_width_p-1:0]   i_addr,
    input  logic [data_width_p-1:0]   i_data,
    input  logic [data_width_p/8-1:0] i_wmask,
    output logic [data_width_p-1:0]   o_data
);

    // One independent byte-wide array per lane keeps the byte enables
    // trivially mappable onto block RAM write-enable columns.
    generate
        for (genvar gi = 0; gi < data_width_p/8; gi++) begin : g_lane
            logic [7:0] r_mem [els_p];
            logic [7:0] r_q;

            always_ff @(posedge i_clk) begin
                if (i_v) begin
                    if (i_w) begin
                        if (i_wmask[gi]) begin
                            r_mem[i_addr] <= i_data[gi*8 +: 8];
                        end
                    end else begin
                        r_q <= r_mem[i_addr];
                    end
                end
            end

            assign o_data[gi*8 +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/axi3_burst_mem_slave.sv
// AXI3 slave memory model: serves one INCR/FIXED burst (up to 16 beats) at a
// time, read or write, out of a byte-masked synchronous-read RAM.
//   aclk / aresetn      : clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w*: write address / data channels (wid ignored)
//   s_axi_b*            : write response channel
//   s_axi_ar* / s_axi_r*: read address / data channels
// Byte address base_addr_p maps to RAM word 0; word index wraps modulo
// mem_els_p. Unsupported size/burst, or a wlast that disagrees with the beat
// count, produce SLVERR.
module axi3_burst_mem_slave
    import axi3_pkg::*;
#(
    parameter int                     data_width_p = 64,
    parameter int                     addr_width_p = 32,
    parameter int                     id_width_p   = 6,
    parameter int                     mem_els_p    = 8192,
    parameter logic [addr_width_p-1:0] base_addr_p = 32'h8000_0000
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [id_width_p-1:0]     s_axi_awid,
    input  logic [addr_width_p-1:0]   s_axi_awaddr,
    input  logic [3:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [id_width_p-1:0]     s_axi_wid,
    input  logic [data_width_p-1:0]   s_axi_wdata,
    input  logic [data_width_p/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [id_width_p-1:0]     s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [id_width_p-1:0]     s_axi_arid,
    input  logic [addr_width_p-1:0]   s_axi_araddr,
    input  logic [3:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [id_width_p-1:0]     s_axi_rid,
    output logic [data_width_p-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int         BYTES   = data_width_p / 8;
    localparam int         LG_B    = $clog2(BYTES);
    localparam int         LG_ELS  = $clog2(mem_els_p);
    localparam logic [2:0] SIZE_OK = 3'(LG_B);

    state_e                  r_state,     w_state_next;
    logic [id_width_p-1:0]   r_id,        w_id_next;
    logic [3:0]              r_len,       w_len_next;
    logic [3:0]              r_beat,      w_beat_next;
    logic [1:0]              r_burst,     w_burst_next;
    logic [LG_ELS-1:0]       r_idx,       w_idx_next;
    logic                    r_cfg_err,   w_cfg_err_next;  // size/burst error: suppresses RAM writes
    logic                    r_err,       w_err_next;      // any error: selects SLVERR
    logic                    r_rd_prio,   w_rd_prio_next;

    logic                    w_aw_grant;
    logic                    w_ar_grant;
    logic [LG_ELS-1:0]       w_aw_idx;
    logic [LG_ELS-1:0]       w_ar_idx;
    logic [LG_ELS-1:0]       w_idx_adv;
    logic                    w_last_beat;
    logic                    w_ram_v;
    logic                    w_ram_w;
    logic [data_width_p-1:0] w_ram_q;
    logic                    w_unused_ok;

    assign w_unused_ok = ^s_axi_wid;

    // Arbitration: a lone request always wins; on contention rd_prio decides.
    assign w_aw_grant = s_axi_awvalid && !(s_axi_arvalid && r_rd_prio);
    assign w_ar_grant = s_axi_arvalid && !w_aw_grant;

    assign w_aw_idx  = LG_ELS'((s_axi_awaddr - base_addr_p) >> LG_B);
    assign w_ar_idx  = LG_ELS'((s_axi_araddr - base_addr_p) >> LG_B);
    assign w_idx_adv = (r_burst == BURST_INCR) ? r_idx + LG_ELS'(1) : r_idx;

    // Burst length is counted, never inferred from wlast.
    assign w_last_beat = (r_beat == r_len);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_burst   <= '0;
            r_idx     <= '0;
            r_cfg_err <= 1'b0;
            r_err     <= 1'b0;
            r_rd_prio <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_id      <= w_id_next;
            r_len     <= w_len_next;
            r_beat    <= w_beat_next;
            r_burst   <= w_burst_next;
            r_idx     <= w_idx_next;
            r_cfg_err <= w_cfg_err_next;
            r_err     <= w_err_next;
            r_rd_prio <= w_rd_prio_next;
        end
    end

    // Every ready/valid is qualified with aresetn so nothing handshakes, and
    // the RAM is never written, while reset is held.
    always_comb begin
        w_state_next   = r_state;
        w_id_next      = r_id;
        w_len_next     = r_len;
        w_beat_next    = r_beat;
        w_burst_next   = r_burst;
        w_idx_next     = r_idx;
        w_cfg_err_next = r_cfg_err;
        w_err_next     = r_err;
        w_rd_prio_next = r_rd_prio;
        s_axi_awready  = 1'b0;
        s_axi_arready  = 1'b0;
        s_axi_wready   = 1'b0;
        s_axi_bvalid   = 1'b0;
        s_axi_rvalid   = 1'b0;
        w_ram_v        = 1'b0;
        w_ram_w        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                s_axi_awready = aresetn && w_aw_grant;
                s_axi_arready = aresetn && w_ar_grant;
                if (aresetn && w_aw_grant) begin
                    w_id_next      = s_axi_awid;
                    w_len_next     = s_axi_awlen;
                    w_burst_next   = s_axi_awburst;
                    w_idx_next     = w_aw_idx;
                    w_beat_next    = '0;
                    w_cfg_err_next = burst_cfg_err(s_axi_awsize, SIZE_OK, s_axi_awburst);
                    w_err_next     = w_cfg_err_next;
                    w_rd_prio_next = !r_rd_prio;
                    w_state_next   = ST_WR_DATA;
                end else if (aresetn && w_ar_grant) begin
                    w_id_next      = s_axi_arid;
                    w_len_next     = s_axi_arlen;
                    w_burst_next   = s_axi_arburst;
                    w_idx_next     = w_ar_idx;
                    w_beat_next    = '0;
                    w_cfg_err_next = burst_cfg_err(s_axi_arsize, SIZE_OK, s_axi_arburst);
                    w_err_next     = w_cfg_err_next;
                    w_rd_prio_next = !r_rd_prio;
                    w_state_next   = ST_RD_REQ;
                end
            end

            ST_WR_DATA: begin
                s_axi_wready = aresetn;
                if (aresetn && s_axi_wvalid) begin
                    // A wlast mismatch is reported but the beat is still stored.
                    w_ram_v = !r_cfg_err;
                    w_ram_w = 1'b1;
                    if (s_axi_wlast != w_last_beat) begin
                        w_err_next = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_next = ST_WR_RESP;
                    end else begin
                        w_beat_next = r_beat + 4'd1;
                        w_idx_next  = w_idx_adv;
                    end
                end
            end

            ST_WR_RESP: begin
                s_axi_bvalid = aresetn;
                if (aresetn && s_axi_bready) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_RD_REQ: begin
                w_ram_v      = aresetn;
                w_state_next = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                // No RAM access here, so the registered RAM output holds
                // rdata stable through any rready stall.
                s_axi_rvalid = aresetn;
                if (aresetn && s_axi_rready) begin
                    if (w_last_beat) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beat_next  = r_beat + 4'd1;
                        w_idx_next   = w_idx_adv;
                        w_state_next = ST_RD_REQ;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Payload outputs are zero whenever their valid is low (covers reset).
    assign s_axi_bid   = s_axi_bvalid ? r_id : '0;
    assign s_axi_bresp = (s_axi_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rid   = s_axi_rvalid ? r_id : '0;
    assign s_axi_rresp = (s_axi_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata = s_axi_rvalid ? w_ram_q : '0;
    assign s_axi_rlast = s_axi_rvalid && w_last_beat;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (data_width_p),
        .addr_width_p (LG_ELS)
    ) u_mem (
        .i_clk   (aclk),
        .i_v     (w_ram_v),
        .i_w     (w_ram_w),
        .i_addr  (r_idx),
        .i_data  (s_axi_wdata),
        .i_wmask (s_axi_wstrb),
        .o_data  (w_ram_q)
    );

endmodule

// File: tb/tb_axi3_burst_mem_slave.sv
// Directed testbench for axi3_burst_mem_slave. Inputs change 1 ns after the
// rising edge; outputs are sampled 1-2 ns after the edge.
module tb_axi3_burst_mem_slave;

    localparam int         LIM    = 40;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [5:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [3:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [5:0]  s_axi_wid;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [5:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [5:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [3:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [5:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] rx [16];

    always #5 aclk = ~aclk;

    axi3_burst_mem_slave dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wid     (s_axi_wid),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The two address readies must never be high together.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            chk("rdy_excl", 64'(s_axi_awready & s_axi_arready), 64'd0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(s_axi_awready), 64'd0);
        chk({tag, "_arready"}, 64'(s_axi_arready), 64'd0);
        chk({tag, "_wready"},  64'(s_axi_wready),  64'd0);
        chk({tag, "_bvalid"},  64'(s_axi_bvalid),  64'd0);
        chk({tag, "_rvalid"},  64'(s_axi_rvalid),  64'd0);
        chk({tag, "_bid"},     64'(s_axi_bid),     64'd0);
        chk({tag, "_bresp"},   64'(s_axi_bresp),   64'd0);
        chk({tag, "_rid"},     64'(s_axi_rid),     64'd0);
        chk({tag, "_rresp"},   64'(s_axi_rresp),   64'd0);
        chk({tag, "_rdata"},   s_axi_rdata,        64'd0);
        chk({tag, "_rlast"},   64'(s_axi_rlast),   64'd0);
    endtask

    // All phase tasks are entered and left 1 ns after a rising edge.
    task automatic aw_phase(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_awready && n < LIM) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= LIM) chk("aw_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < LIM) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= LIM) chk("ar_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // Sends nb beats of a burst of length len+1; drop clears wlast on the final beat.
    task automatic w_phase(input int nb, input int len, input bit drop);
        int n;
        for (int b = 0; b < nb; b++) begin
            s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = (b == len) && !drop; s_axi_wvalid = 1'b1;
            #1;
            n = 0;
            while (!s_axi_wready && n < LIM) begin
                @(posedge aclk); #1; n++;
            end
            chk("w_gap", 64'(n), 64'd0);
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [5:0] id, input logic [1:0] resp, input int stall);
        for (int k = 0; k < stall; k++) begin
            chk("b_stall_valid", 64'(s_axi_bvalid), 64'd1);
            chk("b_stall_id",    64'(s_axi_bid),    64'(id));
            chk("b_stall_resp",  64'(s_axi_bresp),  64'(resp));
            @(posedge aclk); #1;
        end
        s_axi_bready = 1'b1;
        #1;
        chk("b_valid", 64'(s_axi_bvalid), 64'd1);
        chk("b_id",    64'(s_axi_bid),    64'(id));
        chk("b_resp",  64'(s_axi_bresp),  64'(resp));
        $display("WR id=%0d bresp=%0d", s_axi_bid, s_axi_bresp);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
        chk("b_drop", 64'(s_axi_bvalid), 64'd0);
    endtask

    // Expects rx[0..len]; cd=0 skips data comparison; rnd inserts random stalls.
    task automatic r_phase(input logic [5:0] id, input int len, input logic [1:0] resp,
                           input bit cd, input bit rnd);
        int n;
        int k;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!s_axi_rvalid && n < LIM) begin
                @(posedge aclk); #1; n++;
            end
            chk("r_gap", 64'(n), 64'd1);
            k = rnd ? int'($urandom_range(0, 3)) : 0;
            for (int s = 0; s < k; s++) begin
                chk("r_stall_valid", 64'(s_axi_rvalid), 64'd1);
                if (cd) chk("r_stall_data", s_axi_rdata, rx[b]);
                chk("r_stall_last", 64'(s_axi_rlast), 64'(b == len));
                chk("r_stall_id",   64'(s_axi_rid),   64'(id));
                @(posedge aclk); #1;
            end
            s_axi_rready = 1'b1;
            #1;
            if (cd) chk("r_data", s_axi_rdata, rx[b]);
            chk("r_last", 64'(s_axi_rlast), 64'(b == len));
            chk("r_id",   64'(s_axi_rid),   64'(id));
            chk("r_resp", 64'(s_axi_rresp), 64'(resp));
            @(posedge aclk); #1;
            s_axi_rready = 1'b0;
        end
        $display("RD id=%0d beats=%0d rresp=%0d", id, len + 1, resp);
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit drop,
                            input logic [1:0] resp, input int stall);
        aw_phase(id, addr, len, size, burst);
        w_phase(int'(len) + 1, int'(len), drop);
        b_phase(id, resp, stall);
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [1:0] resp, input bit cd, input bit rnd);
        ar_phase(id, addr, len, 3'd3, burst);
        r_phase(id, int'(len), resp, cd, rnd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wid = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; rx[i] = '0; end

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk_all_zero("rst");
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Arbitration: simultaneous requests, write first (rd_prio=0), then read
        s_axi_awid = 6'd1; s_axi_awaddr = 32'h8000_0500; s_axi_awlen = 4'd0;
        s_axi_awsize = 3'd3; s_axi_awburst = INCR; s_axi_awvalid = 1'b1;
        s_axi_arid = 6'd2; s_axi_araddr = 32'h8000_0500; s_axi_arlen = 4'd0;
        s_axi_arsize = 3'd3; s_axi_arburst = INCR; s_axi_arvalid = 1'b1;
        #1;
        chk("arb1_awready", 64'(s_axi_awready), 64'd1);
        chk("arb1_arready", 64'(s_axi_arready), 64'd0);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        wd[0] = 64'h0123_4567_89AB_CDEF;
        w_phase(1, 0, 1'b0);
        b_phase(6'd1, OKAY, 0);
        s_axi_awid = 6'd3; s_axi_awaddr = 32'h8000_0508; s_axi_awvalid = 1'b1;
        #1;
        chk("arb2_arready", 64'(s_axi_arready), 64'd1);
        chk("arb2_awready", 64'(s_axi_awready), 64'd0);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        rx[0] = 64'h0123_4567_89AB_CDEF;
        r_phase(6'd2, 0, OKAY, 1'b1, 1'b0);
        wd[0] = 64'h0BAD_F00D_0000_0508;
        aw_phase(6'd3, 32'h8000_0508, 4'd0, 3'd3, INCR);
        w_phase(1, 0, 1'b0);
        b_phase(6'd3, OKAY, 0);

        // Basic INCR write/read, with 5 cycles of bready backpressure
        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) rx[i] = wd[i];
        do_write(6'd5, 32'h8000_0100, 4'd3, 3'd3, INCR, 1'b0, OKAY, 5);
        do_read(6'd6, 32'h8000_0100, 4'd3, INCR, OKAY, 1'b1, 1'b0);

        // Byte strobes on a FIXED burst
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(6'd7, 32'h8000_0000, 4'd0, 3'd3, INCR, 1'b0, OKAY, 0);
        wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; wd[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        ws[0] = 8'h0F; ws[1] = 8'h0F;
        do_write(6'd8, 32'h8000_0000, 4'd1, 3'd3, FIXED, 1'b0, OKAY, 0);
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        rx[0] = 64'hFFFF_FFFF_AAAA_AAAA;
        do_read(6'd8, 32'h8000_0000, 4'd0, INCR, OKAY, 1'b1, 1'b0);

        // 16-beat burst with random rready stalls
        for (int i = 0; i < 16; i++) begin
            wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 17 + 3);
            rx[i] = wd[i];
        end
        do_write(6'd11, 32'h8000_1000, 4'd15, 3'd3, INCR, 1'b0, OKAY, 0);
        do_read(6'd12, 32'h8000_1000, 4'd15, INCR, OKAY, 1'b1, 1'b1);

        // Bad awsize: SLVERR and RAM untouched
        wd[0] = 64'hDEAD_BEEF_0000_0001;
        do_write(6'd13, 32'h8000_0200, 4'd0, 3'd3, INCR, 1'b0, OKAY, 0);
        wd[0] = 64'h5555_5555_5555_5555;
        do_write(6'd14, 32'h8000_0200, 4'd0, 3'd2, INCR, 1'b0, SLVERR, 0);
        rx[0] = 64'hDEAD_BEEF_0000_0001;
        do_read(6'd15, 32'h8000_0200, 4'd0, INCR, OKAY, 1'b1, 1'b0);

        // Missing wlast on the final beat: SLVERR but data written
        wd[0] = 64'hF0F0_F0F0_0000_0000; wd[1] = 64'hF1F1_F1F1_0000_0001;
        do_write(6'd16, 32'h8000_0300, 4'd1, 3'd3, INCR, 1'b1, SLVERR, 0);
        rx[0] = wd[0]; rx[1] = wd[1];
        do_read(6'd17, 32'h8000_0300, 4'd1, INCR, OKAY, 1'b1, 1'b0);

        // WRAP read: every beat SLVERR
        do_read(6'd18, 32'h8000_0100, 4'd3, WRAP, SLVERR, 1'b0, 1'b0);

        // Reset in the middle of a len=7 write after two beats
        wd[0] = 64'h7000_0000_0000_0A00; wd[1] = 64'h7000_0000_0000_0A01;
        aw_phase(6'd19, 32'h8000_0400, 4'd7, 3'd3, INCR);
        w_phase(2, 7, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk_all_zero("midrst");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        rx[0] = wd[0]; rx[1] = wd[1];
        wd[0] = 64'h6666_0000_0000_0600;
        do_write(6'd20, 32'h8000_0600, 4'd0, 3'd3, INCR, 1'b0, OKAY, 0);
        do_read(6'd21, 32'h8000_0400, 4'd1, INCR, OKAY, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
